// File: rtl/beam_idx_buf_if.sv
// Bundle of write-side, stream-side and result signals for beam_idx_buf.
// The o_swap_cnt field exists only when BIDBUF_STAT_EN is defined.
interface beam_idx_buf_if #(
    parameter int BEAM    = 16,
    parameter int RBG_MAX = 64,
    parameter int BW      = 8
);
    localparam int AW = (RBG_MAX > 1) ? $clog2(RBG_MAX) : 1;

    logic                 i_wr_vld;
    logic [AW-1:0]        i_wr_rbg;
    logic [BEAM*BW-1:0]   i_wr_beam;
    logic                 i_wr_done;
    logic [7:0]           i_rbg_size;
    logic                 i_symb_clr;
    logic                 i_rvalid;
    logic                 i_sop;
    logic                 i_eop;

    logic                 o_rvalid;
    logic [7:0]           o_re_num;
    logic [7:0]           o_rbg_num;
    logic                 o_rbg_load;
    logic [BEAM*BW-1:0]   o_beam_idx;
    logic                 o_symb_1st;
    logic                 o_symb_clr;
    logic                 o_err_ovr;
    logic                 o_err_rbg;
`ifdef BIDBUF_STAT_EN
    logic [15:0]          o_swap_cnt;
`endif

    modport master (
        output i_wr_vld, i_wr_rbg, i_wr_beam, i_wr_done, i_rbg_size,
               i_symb_clr, i_rvalid, i_sop, i_eop,
        input  o_rvalid, o_re_num, o_rbg_num, o_rbg_load, o_beam_idx,
               o_symb_1st, o_symb_clr, o_err_ovr, o_err_rbg
`ifdef BIDBUF_STAT_EN
        , input o_swap_cnt
`endif
    );

    modport slave (
        input  i_wr_vld, i_wr_rbg, i_wr_beam, i_wr_done, i_rbg_size,
               i_symb_clr, i_rvalid, i_sop, i_eop,
        output o_rvalid, o_re_num, o_rbg_num, o_rbg_load, o_beam_idx,
               o_symb_1st, o_symb_clr, o_err_ovr, o_err_rbg
`ifdef BIDBUF_STAT_EN
        , output o_swap_cnt
`endif
    );
endinterface

// File: rtl/beam_idx_buf.sv
// Ping-pong buffer of per-RBG sorted beam indices, aligned to the antenna stream.
// Optional BIDBUF_STAT_EN adds a 16-bit swap counter (o_swap_cnt).
module beam_idx_buf #(
    parameter int BEAM    = 16,
    parameter int RBG_MAX = 64,
    parameter int BW      = 8
) (
    input logic          i_clk,
    input logic          i_reset,
    beam_idx_buf_if.slave bus
);
    localparam int AW = (RBG_MAX > 1) ? $clog2(RBG_MAX) : 1;
    localparam int VW = BEAM * BW;
    localparam logic [7:0] RBG_LAST = 8'(RBG_MAX - 1);

    function automatic logic [VW-1:0] identity_vec();
        logic [VW-1:0] v;
        v = {VW{1'b0}};
        for (int k = 0; k < BEAM; k++) begin
            v[k*BW +: BW] = BW'(k);
        end
        return v;
    endfunction

    logic [VW-1:0] bank_r [2][RBG_MAX];
    logic [1:0]    valid_r;
    logic          wr_bank_r;
    logic          pending_r;
    logic [7:0]    re_r;
    logic [7:0]    rbg_r;
    logic          active_r;
    logic          rvalid_r;
    logic          load_r;
    logic [VW-1:0] beam_r;
    logic          symb_1st_r;
    logic          symb_clr_r;
    logic          err_ovr_r;
    logic          err_rbg_r;

    logic          beat_s;
    logic          sop_s;
    logic          swap_s;
    logic          rd_bank_s;
    logic          rd_valid_s;
    logic          wr_bank_n_s;
    logic          pend_keep_s;
    logic          done_s;
    logic [7:0]    size_m1_s;
    logic [7:0]    re_n_s;
    logic [7:0]    rbg_n_s;
    logic          active_n_s;
    logic          load_s;
    logic          sat_hit_s;

    // A clear cycle drops the stream beat and the bank-complete pulse.
    assign beat_s      = bus.i_rvalid & ~bus.i_symb_clr;
    assign sop_s       = beat_s & bus.i_sop;
    assign swap_s      = sop_s & pending_r;
    assign rd_bank_s   = swap_s ? wr_bank_r : ~wr_bank_r;
    assign rd_valid_s  = valid_r[rd_bank_s];
    assign wr_bank_n_s = swap_s ? ~wr_bank_r : wr_bank_r;
    assign pend_keep_s = pending_r & ~swap_s;
    assign done_s      = bus.i_wr_done & ~bus.i_symb_clr;
    assign size_m1_s   = (bus.i_rbg_size == 8'd0) ? 8'd0 : (bus.i_rbg_size - 8'd1);

    // RE/RBG position tracking and load-strobe generation for the current beat.
    always_comb begin
        re_n_s     = re_r;
        rbg_n_s    = rbg_r;
        active_n_s = active_r;
        load_s     = 1'b0;
        sat_hit_s  = 1'b0;
        if (sop_s) begin
            re_n_s     = 8'd0;
            rbg_n_s    = 8'd0;
            load_s     = 1'b1;
            active_n_s = ~bus.i_eop;
        end else if (beat_s && active_r) begin
            // >= keeps a mid-RBG shrink of i_rbg_size from running re past the end
            if (re_r >= size_m1_s) begin
                re_n_s = 8'd0;
                load_s = 1'b1;
                if (rbg_r >= RBG_LAST) begin
                    sat_hit_s = 1'b1;
                end else begin
                    rbg_n_s = rbg_r + 8'd1;
                end
            end else begin
                re_n_s = re_r + 8'd1;
            end
            if (bus.i_eop) begin
                active_n_s = 1'b0;
            end else begin
                active_n_s = active_r;
            end
        end else begin
            active_n_s = active_r;
        end
    end

    // Index storage: writes always land in the current write bank, even on a clear cycle.
    always_ff @(posedge i_clk) begin
        if (bus.i_wr_vld) begin
            bank_r[wr_bank_r][bus.i_wr_rbg] <= bus.i_wr_beam;
        end
    end

    // Bank control, counters, error flags and registered stream outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_r    <= 2'b00;
            wr_bank_r  <= 1'b0;
            pending_r  <= 1'b0;
            re_r       <= 8'd0;
            rbg_r      <= 8'd0;
            active_r   <= 1'b0;
            rvalid_r   <= 1'b0;
            load_r     <= 1'b0;
            beam_r     <= {VW{1'b0}};
            symb_1st_r <= 1'b0;
            symb_clr_r <= 1'b0;
            err_ovr_r  <= 1'b0;
            err_rbg_r  <= 1'b0;
        end else begin
            rvalid_r   <= bus.i_rvalid;
            symb_clr_r <= bus.i_symb_clr;
            load_r     <= beat_s & load_s;
            if (bus.i_symb_clr) begin
                valid_r   <= 2'b00;
                pending_r <= 1'b0;
                re_r      <= 8'd0;
                rbg_r     <= 8'd0;
                active_r  <= 1'b0;
            end else begin
                wr_bank_r <= wr_bank_n_s;
                re_r      <= re_n_s;
                rbg_r     <= rbg_n_s;
                active_r  <= active_n_s;
                if (done_s) begin
                    pending_r            <= 1'b1;
                    valid_r[wr_bank_n_s] <= 1'b1;
                    if (pend_keep_s) begin
                        err_ovr_r <= 1'b1;
                    end
                end else begin
                    pending_r <= pend_keep_s;
                end
                if (sat_hit_s) begin
                    err_rbg_r <= 1'b1;
                end
            end
            if (beat_s && load_s) begin
                beam_r <= rd_valid_s ? bank_r[rd_bank_s][rbg_n_s[AW-1:0]] : identity_vec();
            end
            if (sop_s) begin
                symb_1st_r <= ~rd_valid_s;
            end
        end
    end

`ifdef BIDBUF_STAT_EN
    logic [15:0] swap_cnt_r;

    // Swap statistics, wrapping naturally at 16 bits.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            swap_cnt_r <= 16'd0;
        end else if (bus.i_symb_clr) begin
            swap_cnt_r <= 16'd0;
        end else if (swap_s) begin
            swap_cnt_r <= swap_cnt_r + 16'd1;
        end
    end

    assign bus.o_swap_cnt = swap_cnt_r;
`endif

    assign bus.o_rvalid   = rvalid_r;
    assign bus.o_re_num   = re_r;
    assign bus.o_rbg_num  = rbg_r;
    assign bus.o_rbg_load = load_r;
    assign bus.o_beam_idx = beam_r;
    assign bus.o_symb_1st = symb_1st_r;
    assign bus.o_symb_clr = symb_clr_r;
    assign bus.o_err_ovr  = err_ovr_r;
    assign bus.o_err_rbg  = err_rbg_r;
endmodule

// File: tb/tb_beam_idx_buf.sv
// Directed self-checking bench for beam_idx_buf: reset, identity path, swap,
// overrun, saturation, clear priority, gaps with size 0.
module tb_beam_idx_buf;
    localparam int BEAM    = 16;
    localparam int RBG_MAX = 64;
    localparam int BW      = 8;
    localparam int VW      = BEAM * BW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    beam_idx_buf_if #(.BEAM(BEAM), .RBG_MAX(RBG_MAX), .BW(BW)) bif ();

    beam_idx_buf #(.BEAM(BEAM), .RBG_MAX(RBG_MAX), .BW(BW)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bif.slave)
    );

    function automatic logic [VW-1:0] ramp(input logic [7:0] base);
        logic [VW-1:0] v;
        for (int k = 0; k < BEAM; k++) v[k*BW +: BW] = base + 8'(k);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.i_wr_vld   = 1'b0;
        bif.i_wr_rbg   = '0;
        bif.i_wr_beam  = '0;
        bif.i_wr_done  = 1'b0;
        bif.i_symb_clr = 1'b0;
        bif.i_rvalid   = 1'b0;
        bif.i_sop      = 1'b0;
        bif.i_eop      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic beat(input logic sop, input logic eop);
        bif.i_rvalid = 1'b1;
        bif.i_sop    = sop;
        bif.i_eop    = eop;
        step();
        bif.i_rvalid = 1'b0;
        bif.i_sop    = 1'b0;
        bif.i_eop    = 1'b0;
    endtask

    task automatic write_rbg(input int rbg, input logic [VW-1:0] vec);
        bif.i_wr_vld  = 1'b1;
        bif.i_wr_rbg  = 6'(rbg);
        bif.i_wr_beam = vec;
        step();
        bif.i_wr_vld  = 1'b0;
    endtask

    task automatic pulse_done();
        bif.i_wr_done = 1'b1;
        step();
        bif.i_wr_done = 1'b0;
    endtask

    task automatic test_reset();
        bif.i_rbg_size = 8'd4;
        do_reset();
        total_cnt++; if (bif.o_rvalid !== 1'b0) $display("FAIL reset rvalid got %b want 0", bif.o_rvalid); else pass_cnt++;
        total_cnt++; if (bif.o_re_num !== 8'd0) $display("FAIL reset re got %0d want 0", bif.o_re_num); else pass_cnt++;
        total_cnt++; if (bif.o_rbg_num !== 8'd0) $display("FAIL reset rbg got %0d want 0", bif.o_rbg_num); else pass_cnt++;
        total_cnt++; if (bif.o_rbg_load !== 1'b0) $display("FAIL reset load got %b want 0", bif.o_rbg_load); else pass_cnt++;
        total_cnt++; if (bif.o_beam_idx !== {VW{1'b0}}) $display("FAIL reset beam got %h want 0", bif.o_beam_idx); else pass_cnt++;
        total_cnt++; if (bif.o_symb_1st !== 1'b0) $display("FAIL reset symb_1st got %b want 0", bif.o_symb_1st); else pass_cnt++;
        total_cnt++; if (bif.o_symb_clr !== 1'b0) $display("FAIL reset symb_clr got %b want 0", bif.o_symb_clr); else pass_cnt++;
        total_cnt++; if (bif.o_err_ovr !== 1'b0) $display("FAIL reset err_ovr got %b want 0", bif.o_err_ovr); else pass_cnt++;
        total_cnt++; if (bif.o_err_rbg !== 1'b0) $display("FAIL reset err_rbg got %b want 0", bif.o_err_rbg); else pass_cnt++;
    endtask

    task automatic test_default_path();
        bif.i_rbg_size = 8'd4;
        for (int i = 0; i < 16; i++) begin
            beat(i == 0, i == 15);
            total_cnt++; if (bif.o_rvalid !== 1'b1) $display("FAIL default rvalid beat %0d got %b want 1", i, bif.o_rvalid); else pass_cnt++;
            total_cnt++; if (bif.o_rbg_load !== (i % 4 == 0)) $display("FAIL default load beat %0d got %b want %b", i, bif.o_rbg_load, (i % 4 == 0)); else pass_cnt++;
            total_cnt++; if (bif.o_re_num !== 8'(i % 4)) $display("FAIL default re beat %0d got %0d want %0d", i, bif.o_re_num, i % 4); else pass_cnt++;
            total_cnt++; if (bif.o_rbg_num !== 8'(i / 4)) $display("FAIL default rbg beat %0d got %0d want %0d", i, bif.o_rbg_num, i / 4); else pass_cnt++;
            total_cnt++; if (bif.o_symb_1st !== 1'b1) $display("FAIL default symb_1st beat %0d got %b want 1", i, bif.o_symb_1st); else pass_cnt++;
            total_cnt++; if (bif.o_beam_idx !== ramp(8'h00)) $display("FAIL default beam beat %0d got %h want %h", i, bif.o_beam_idx, ramp(8'h00)); else pass_cnt++;
        end
    endtask

    task automatic test_swap();
        logic [VW-1:0] exp_v;
        for (int r = 0; r < 4; r++) write_rbg(r, ramp(8'(8'h20 + r * 16)));
        pulse_done();
        bif.i_rbg_size = 8'd4;
        for (int i = 0; i < 16; i++) begin
            bif.i_wr_done = (i == 5);
            beat(i == 0, i == 15);
            bif.i_wr_done = 1'b0;
            if (i % 4 == 0) begin
                exp_v = ramp(8'(8'h20 + (i / 4) * 16));
                total_cnt++; if (bif.o_beam_idx !== exp_v) $display("FAIL swap sym2 beam rbg %0d got %h want %h", i / 4, bif.o_beam_idx, exp_v); else pass_cnt++;
            end
        end
        total_cnt++; if (bif.o_symb_1st !== 1'b0) $display("FAIL swap sym2 symb_1st got %b want 0", bif.o_symb_1st); else pass_cnt++;
        for (int r = 0; r < 4; r++) write_rbg(r, ramp(8'(8'h80 + r * 16)));
        for (int i = 0; i < 8; i++) begin
            beat(i == 0, i == 7);
            if (i == 0) begin
                total_cnt++; if (bif.o_beam_idx !== ramp(8'h80)) $display("FAIL swap sym3 beam rbg0 got %h want %h", bif.o_beam_idx, ramp(8'h80)); else pass_cnt++;
            end
            if (i == 4) begin
                total_cnt++; if (bif.o_beam_idx !== ramp(8'h90)) $display("FAIL swap sym3 beam rbg1 got %h want %h", bif.o_beam_idx, ramp(8'h90)); else pass_cnt++;
            end
        end
    endtask

    task automatic test_overrun();
        pulse_done();
        total_cnt++; if (bif.o_err_ovr !== 1'b0) $display("FAIL overrun first done got %b want 0", bif.o_err_ovr); else pass_cnt++;
        pulse_done();
        total_cnt++; if (bif.o_err_ovr !== 1'b1) $display("FAIL overrun second done got %b want 1", bif.o_err_ovr); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            beat(i == 0, i == 3);
            if (i == 0) begin
                total_cnt++; if (bif.o_beam_idx !== ramp(8'h20)) $display("FAIL overrun sym beam got %h want %h", bif.o_beam_idx, ramp(8'h20)); else pass_cnt++;
                total_cnt++; if (bif.o_symb_1st !== 1'b0) $display("FAIL overrun sym symb_1st got %b want 0", bif.o_symb_1st); else pass_cnt++;
            end
        end
        total_cnt++; if (bif.o_err_ovr !== 1'b1) $display("FAIL overrun sticky got %b want 1", bif.o_err_ovr); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        total_cnt++; if (bif.o_err_ovr !== 1'b0) $display("FAIL sat err_ovr after reset got %b want 0", bif.o_err_ovr); else pass_cnt++;
        bif.i_rbg_size = 8'd1;
        for (int i = 0; i < 70; i++) begin
            beat(i == 0, i == 69);
            total_cnt++; if (bif.o_rbg_num !== 8'((i > 63) ? 63 : i)) $display("FAIL sat rbg beat %0d got %0d want %0d", i, bif.o_rbg_num, (i > 63) ? 63 : i); else pass_cnt++;
            total_cnt++; if (bif.o_rbg_load !== 1'b1) $display("FAIL sat load beat %0d got %b want 1", i, bif.o_rbg_load); else pass_cnt++;
            total_cnt++; if (bif.o_err_rbg !== (i >= 64)) $display("FAIL sat err_rbg beat %0d got %b want %b", i, bif.o_err_rbg, (i >= 64)); else pass_cnt++;
        end
        total_cnt++; if (bif.o_beam_idx !== ramp(8'h00)) $display("FAIL sat beam got %h want %h", bif.o_beam_idx, ramp(8'h00)); else pass_cnt++;
    endtask

    task automatic test_clear_priority();
        do_reset();
        bif.i_rbg_size = 8'd2;
        write_rbg(0, ramp(8'hA0));
        pulse_done();
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        total_cnt++; if (bif.o_rbg_num !== 8'd1) $display("FAIL clr pre rbg got %0d want 1", bif.o_rbg_num); else pass_cnt++;
        bif.i_symb_clr = 1'b1;
        bif.i_wr_done  = 1'b1;
        beat(1'b1, 1'b0);
        bif.i_symb_clr = 1'b0;
        bif.i_wr_done  = 1'b0;
        total_cnt++; if (bif.o_symb_clr !== 1'b1) $display("FAIL clr symb_clr got %b want 1", bif.o_symb_clr); else pass_cnt++;
        total_cnt++; if (bif.o_rbg_load !== 1'b0) $display("FAIL clr load got %b want 0", bif.o_rbg_load); else pass_cnt++;
        total_cnt++; if (bif.o_rbg_num !== 8'd0) $display("FAIL clr rbg got %0d want 0", bif.o_rbg_num); else pass_cnt++;
        total_cnt++; if (bif.o_re_num !== 8'd0) $display("FAIL clr re got %0d want 0", bif.o_re_num); else pass_cnt++;
        step();
        total_cnt++; if (bif.o_symb_clr !== 1'b0) $display("FAIL clr symb_clr pulse got %b want 0", bif.o_symb_clr); else pass_cnt++;
        beat(1'b1, 1'b0);
        total_cnt++; if (bif.o_beam_idx !== ramp(8'h00)) $display("FAIL clr next beam got %h want %h", bif.o_beam_idx, ramp(8'h00)); else pass_cnt++;
        total_cnt++; if (bif.o_symb_1st !== 1'b1) $display("FAIL clr next symb_1st got %b want 1", bif.o_symb_1st); else pass_cnt++;
        beat(1'b0, 1'b1);
        pulse_done();
        total_cnt++; if (bif.o_err_ovr !== 1'b0) $display("FAIL clr pending cleared err_ovr got %b want 0", bif.o_err_ovr); else pass_cnt++;
    endtask

    task automatic test_gaps_size0();
        do_reset();
        bif.i_rbg_size = 8'd0;
        for (int c = 0; c < 8; c++) begin
            bif.i_rvalid = (c % 2 == 0);
            bif.i_sop    = (c == 0);
            bif.i_eop    = (c == 6);
            step();
            total_cnt++; if (bif.o_rvalid !== (c % 2 == 0)) $display("FAIL gap rvalid cyc %0d got %b want %b", c, bif.o_rvalid, (c % 2 == 0)); else pass_cnt++;
            total_cnt++; if (bif.o_rbg_load !== (c % 2 == 0)) $display("FAIL gap load cyc %0d got %b want %b", c, bif.o_rbg_load, (c % 2 == 0)); else pass_cnt++;
            total_cnt++; if (bif.o_rbg_num !== 8'(c / 2)) $display("FAIL gap rbg cyc %0d got %0d want %0d", c, bif.o_rbg_num, c / 2); else pass_cnt++;
            total_cnt++; if (bif.o_re_num !== 8'd0) $display("FAIL gap re cyc %0d got %0d want 0", c, bif.o_re_num); else pass_cnt++;
        end
        idle_inputs();
        beat(1'b0, 1'b0);
        total_cnt++; if (bif.o_rbg_load !== 1'b0) $display("FAIL post-eop load got %b want 0", bif.o_rbg_load); else pass_cnt++;
        total_cnt++; if (bif.o_rbg_num !== 8'd3) $display("FAIL post-eop rbg held got %0d want 3", bif.o_rbg_num); else pass_cnt++;
    endtask

    initial begin
        idle_inputs();
        bif.i_rbg_size = 8'd4;
        test_reset();
        test_default_path();
        test_swap();
        test_overrun();
        test_saturation();
        test_clear_priority();
        test_gaps_size0();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/beam_idx_buf.md
Name: beam_idx_buf

Overview:
- Sits directly upstream of the codeword-selection stage. Stores the sorted beam indices produced per RBG by the beam-sort engine in a ping-pong buffer.
- Tracks RE/RBG position in the incoming antenna stream. Presents the per-RBG beam-index vector, an RBG load strobe, re/rbg counters and first-symbol/clear flags aligned to the stream.
- The stage it feeds uses these to latch per-beam codewords.

Parameters:
- BEAM, 16, beams per RBG (index vector length).
- RBG_MAX, 64, RBG entries per bank; power of two.
- BW, 8, bits per beam index.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_wr_vld  in  1  write one RBG's sorted indices
- i_wr_rbg  in  log2(RBG_MAX)  RBG address of write
- i_wr_beam  in  BEAM*BW  sorted indices, beam k at [k*BW+:BW]
- i_wr_done  in  1  pulse: write bank complete, request swap
- i_rbg_size  in  8  REs per RBG; 0 treated as 1
- i_symb_clr  in  1  pulse: invalidate both banks
- i_rvalid  in  1  antenna stream beat valid
- i_sop  in  1  first beat of symbol
- i_eop  in  1  last beat of symbol
- o_rvalid  out  1  registered i_rvalid
- o_re_num  out  8  RE index within current RBG
- o_rbg_num  out  8  current RBG index
- o_rbg_load  out  1  first beat of an RBG
- o_beam_idx  out  BEAM*BW  index vector for o_rbg_num, valid when o_rbg_load
- o_symb_1st  out  1  current symbol uses default indices
- o_symb_clr  out  1  registered i_symb_clr
- o_err_ovr  out  1  sticky: swap request while previous still pending
- o_err_rbg  out  1  sticky: rbg counter hit RBG_MAX-1 and wrapped attempt

Behaviour:
- Reset: all outputs 0, both banks invalid, wr_bank=0, rd_bank=1, pending=0, counters 0.
- Write side:
  - i_wr_vld writes i_wr_beam to bank[wr_bank][i_wr_rbg].
  - i_wr_done sets pending=1 and marks wr_bank valid.
  - If pending already 1: o_err_ovr set; the second done is otherwise treated the same (bank stays valid).
- Swap:
  - Occurs only on an accepted beat with i_sop=1 while pending=1.
  - Swap exchanges wr_bank/rd_bank and clears pending. The read for that beat uses the new rd_bank.
  - Swap never happens mid-symbol.
- Counters (beats with i_rvalid=1 only):
  - On i_sop: re=0, rbg=0.
  - Otherwise re+1. When re == size-1, re wraps to 0 and rbg+1.
  - rbg saturates at RBG_MAX-1. An increment attempt at saturation sets o_err_rbg.
  - After an i_eop beat, counters are held until the next i_sop.
- Load strobe: asserted on beats where i_sop=1, or where re wrapped to 0.
- Outputs: registered 1-cycle latency from the input beat; o_rvalid, o_re_num, o_rbg_num, o_rbg_load, o_beam_idx and o_symb_1st all align.
- o_beam_idx source:
  - bank[rd_bank][rbg] if rd_bank is valid.
  - Otherwise default identity: beam k = k.
  - Updated only on load beats; held otherwise.
- o_symb_1st: 1 when rd_bank is invalid at the i_sop beat (after any swap). Held for the whole symbol.
- i_symb_clr:
  - Both banks invalid, pending=0, counters 0.
  - Has priority over same-cycle i_wr_done and i_sop; those are dropped, but same-cycle i_wr_vld data is still written.
  - o_symb_clr follows 1 cycle later.
- i_rvalid=0: counters held, o_rvalid=0, o_rbg_load=0.
- Reset mid-symbol: full return to reset state; the next symbol requires i_sop.

Optional Feature:
- BIDBUF_STAT_EN:
  - Defined: adds output o_swap_cnt[15:0], reset 0, +1 per swap, wraps at 0xFFFF→0, cleared by i_symb_clr.
  - Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Default path: reset, size=4, symbol of 16 beats with no writes. Load at beats 0,4,8,12. o_rbg_num 0..3. o_beam_idx = identity 0..15. o_symb_1st=1.
- Swap: write RBG0..3 with beam k = 0x20+rbg*16+k, done, then sop. Symbol 2 RBG2 shows 0x40..0x4F, o_symb_1st=0. A done mid-symbol causes no swap until the next sop.
- Overrun: two i_wr_done with no intervening sop. o_err_ovr=1 and stays 1 through later symbols until reset.
- Saturation: RBG_MAX=64, size=1, 70 beats. o_rbg_num stops at 63 and o_err_rbg=1.
- Clear priority: i_symb_clr together with i_sop and a pending swap. No swap, next symbol uses identity, o_symb_1st=1, o_symb_clr pulses 1 cycle later.
- Gaps and size 0: i_rvalid toggled 1010 with size=0 (treated as 1). Load on every valid beat, counters frozen on gaps, o_rvalid mirrors with 1-cycle delay.
